// File: rtl/lab1_imul_client_pkg.sv
// lab1_imul_client_pkg: shared multiplier request/response message types and LFSR helper
package lab1_imul_client_pkg;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } lab1_imul_req_msg_t;
  typedef struct packed {
    logic [31:0] result;
  } lab1_imul_resp_msg_t;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction
endpackage

// File: rtl/lab1_imul_client_fifo.sv
// lab1_imul_client_fifo: in-order expected-result FIFO; enq and deq may fire together even when full
module lab1_imul_client_fifo #(
  parameter int unsigned p_depth = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enq,
  input  logic [31:0]                enq_data,
  input  logic                       deq,
  output logic [31:0]                deq_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(p_depth):0]   count
);
  localparam int AW = $clog2(p_depth);
  logic [31:0]   mem_q [p_depth];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  always_comb begin
    wr_d  = enq ? wr_q + 1'b1 : wr_q;
    rd_d  = deq ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (AW+1)'(enq) - (AW+1)'(deq);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk)
    if (enq) mem_q[wr_q] <= enq_data;
  assign deq_data = mem_q[rd_q];
  assign full     = cnt_q == (AW+1)'(p_depth);
  assign empty    = cnt_q == '0;
  assign count    = cnt_q;
endmodule

// File: rtl/lab1_imul_client.sv
// lab1_imul_client: self-checking request generator for lab1 multipliers.
// Define LAB1_IMUL_CLIENT_RAND_EN for LFSR operands instead of a=i+1, b=i+2.
module lab1_imul_client
  import lab1_imul_client_pkg::*;
#(
  parameter int unsigned p_max_inflight = 4,
  parameter logic [31:0] p_seed         = 32'h0000_0001
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [15:0]         num_reqs,
  output logic                req_val,
  input  logic                req_rdy,
  output lab1_imul_req_msg_t  req_msg,
  input  logic                resp_val,
  output logic                resp_rdy,
  input  lab1_imul_resp_msg_t resp_msg,
  output logic                done,
  output logic                pass,
  output logic [15:0]         err_count
);
  localparam int AW = $clog2(p_max_inflight);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t      state_q, state_d;
  logic [15:0] num_q, num_d, issued_q, issued_d, err_q, err_d;
  logic        done_q, done_d, pass_q, pass_d;
  logic [31:0] op_a, op_b, head;
  logic [AW:0] cnt;
  logic        full, empty, req_fire, resp_fire, pop, clr, err_inc;
`ifdef LAB1_IMUL_CLIENT_RAND_EN
  logic [31:0] lfsr_q, lfsr_d;
  assign op_a   = lfsr_q;
  assign op_b   = lfsr_step(lfsr_q);
  assign lfsr_d = clr ? p_seed : req_fire ? lfsr_step(op_b) : lfsr_q;
  always_ff @(posedge clk) lfsr_q <= reset ? p_seed : lfsr_d;
`else
  assign op_a = 32'(issued_q) + 32'd1;
  assign op_b = 32'(issued_q) + 32'd2;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      num_q    <= '0;
      issued_q <= '0;
      err_q    <= '0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      issued_q <= issued_d;
      err_q    <= err_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end
  always_comb begin
    clr     = (state_q == IDLE || state_q == DONE) && start;
    state_d = clr ? (num_reqs == 16'd0 ? DONE : RUN)
            : (state_q == RUN && req_fire && issued_q + 16'd1 == num_q) ? DRAIN
            : (state_q == DRAIN && (empty || (cnt == (AW+1)'(1) && pop))) ? DONE
            : state_q;
  end
  // Pop is decided before push so a full FIFO can still accept a request in a draining cycle.
  always_comb begin
    resp_rdy  = state_q == RUN || state_q == DRAIN;
    resp_fire = resp_val && resp_rdy;
    pop       = resp_fire && !empty;
    req_val   = state_q == RUN && issued_q < num_q && (!full || pop);
    req_fire  = req_val && req_rdy;
    req_msg   = {op_a, op_b};
    done      = done_q;
    pass      = pass_q;
    err_count = err_q;
  end
  always_comb begin
    err_inc  = resp_fire && (empty || resp_msg.result != head);
    num_d    = clr ? num_reqs : num_q;
    issued_d = clr ? 16'd0 : issued_q + 16'(req_fire);
    err_d    = clr ? 16'd0 : (err_inc && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
    done_d   = state_q == DONE && !start;
    pass_d   = done_d && err_q == 16'd0;
  end
  lab1_imul_client_fifo #(.p_depth(p_max_inflight)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .enq      (req_fire),
    .enq_data (op_a * op_b),
    .deq      (pop),
    .deq_data (head),
    .full     (full),
    .empty    (empty),
    .count    (cnt)
  );
`ifndef SYNTHESIS
  function automatic string line_trace();
    return $sformatf("seed=%h %h*%h|%0d|%0d", p_seed, req_msg.a, req_msg.b, cnt, err_q);
  endfunction
`endif
endmodule

// File: tb/tb_lab1_imul_client.sv
// tb_lab1_imul_client: table-driven runs against a behavioural multiplier plus multi-cycle corner sequences
module tb_lab1_imul_client;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, req_rdy = 1'b1;
  logic        resp_val = 1'b0, req_val, resp_rdy, done, pass;
  logic [15:0] num_reqs = '0, err_count;
  logic [63:0] req_msg;
  logic [31:0] resp_msg = '0;
  int          n_chk = 0, n_fail = 0, fires = 0, rel = 0, mode = 0;
  logic [63:0] q[$];
  logic        req_fire_s = 1'b0, resp_fire_s = 1'b0;
  logic [63:0] msg_s;
  always #5 clk = ~clk;
  lab1_imul_client dut (
    .clk(clk), .reset(reset), .start(start), .num_reqs(num_reqs),
    .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
    .done(done), .pass(pass), .err_count(err_count)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Behavioural multiplier: mode 0 correct, 1 echoes a, 2 correct but held until rel>0.
  always @(negedge clk) begin
    if (q.size() > 0 && (mode != 2 || rel > 0)) begin
      resp_val = 1'b1;
      resp_msg = mode == 1 ? q[0][63:32] : q[0][63:32] * q[0][31:0];
    end else begin
      resp_val = 1'b0;
      resp_msg = '0;
    end
    #1;
    req_fire_s  = req_val && req_rdy;
    resp_fire_s = resp_val && resp_rdy;
    msg_s       = req_msg;
  end
  always @(posedge clk) begin
    if (reset) q.delete();
    else begin
      if (resp_fire_s) begin
        void'(q.pop_front());
        if (rel > 0) rel--;
      end
      if (req_fire_s) begin
`ifndef LAB1_IMUL_CLIENT_RAND_EN
        chk("req_msg", msg_s, {32'(fires + 1), 32'(fires + 2)});
`endif
        q.push_back(msg_s);
        fires++;
      end
    end
  end
  task automatic pulse_start(input int n);
    fires = 0;
    @(negedge clk);
    start = 1'b1;
    num_reqs = 16'(n);
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 300 && !done; i++) @(negedge clk);
    #1;
  endtask
  typedef struct {
    int n;
    int md;
    int exp_err;
    bit exp_pass;
  } vec_t;
  vec_t vecs[6];
  initial begin
    vecs[0] = '{3, 0, 0, 1};
    vecs[1] = '{3, 1, 3, 0};
    vecs[2] = '{1, 0, 0, 1};
    vecs[3] = '{6, 0, 0, 1};
    vecs[4] = '{5, 1, 5, 0};
    vecs[5] = '{2, 1, 2, 0};
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst req_val", req_val, 0);
    chk("rst resp_rdy", resp_rdy, 0);
    chk("rst done", done, 0);
    chk("rst pass", pass, 0);
    chk("rst err", err_count, 0);
    foreach (vecs[i]) begin
      mode = vecs[i].md;
      pulse_start(vecs[i].n);
      wait_done();
      chk($sformatf("v%0d done", i), done, 1);
      chk($sformatf("v%0d pass", i), pass, vecs[i].exp_pass);
      chk($sformatf("v%0d err", i), err_count, vecs[i].exp_err);
      chk($sformatf("v%0d fires", i), fires, vecs[i].n);
    end
    // Inflight limit: held responses cap issue at the FIFO depth.
    mode = 2;
    rel = 0;
    pulse_start(6);
    repeat (20) @(negedge clk);
    #1;
    chk("limit fires", fires, 4);
    chk("limit req_val", req_val, 0);
    rel = 1;
    repeat (10) @(negedge clk);
    #1;
    chk("limit release fires", fires, 5);
    chk("limit release req_val", req_val, 0);
    rel = 100;
    wait_done();
    chk("limit pass", pass, 1);
    chk("limit err", err_count, 0);
    // Backpressure on request 1.
    mode = 0;
    req_rdy = 1'b0;
    pulse_start(3);
    req_rdy = 1'b1;
    @(negedge clk);
    req_rdy = 1'b0;
    repeat (5) begin
      #1;
      chk("bp req_val", req_val, 1);
      chk("bp req_msg", req_msg, {32'd2, 32'd3});
      @(negedge clk);
    end
    req_rdy = 1'b1;
    wait_done();
    chk("bp pass", pass, 1);
    chk("bp fires", fires, 3);
    // Zero-length run, then a clean rerun.
    pulse_start(0);
    #1;
    chk("zero done early", done, 0);
    chk("zero req_val 0", req_val, 0);
    @(negedge clk);
    #1;
    chk("zero done", done, 1);
    chk("zero pass", pass, 1);
    chk("zero req_val 1", req_val, 0);
    mode = 1;
    pulse_start(1);
    wait_done();
    chk("echo1 err", err_count, 1);
    mode = 0;
    pulse_start(2);
    wait_done();
    chk("rerun pass", pass, 1);
    chk("rerun err", err_count, 0);
    // Reset with two requests outstanding.
    mode = 2;
    rel = 0;
    req_rdy = 1'b0;
    pulse_start(4);
    req_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    req_rdy = 1'b0;
    chk("mid fires", fires, 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid rst req_val", req_val, 0);
    chk("mid rst resp_rdy", resp_rdy, 0);
    chk("mid rst done", done, 0);
    chk("mid rst pass", pass, 0);
    chk("mid rst err", err_count, 0);
    mode = 0;
    req_rdy = 1'b1;
    pulse_start(1);
    wait_done();
    chk("post rst pass", pass, 1);
    chk("post rst err", err_count, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
